// File: rtl/sensor_read_scheduler_pkg.sv
// sensor_sched_pkg: command encodings, FSM states and timeout data for sensor_read_scheduler
package sensor_sched_pkg;
  typedef enum logic [1:0] {
    OP_SINGLE   = 2'b00,
    OP_START    = 2'b01,
    OP_STOP     = 2'b10,
    OP_STOP_ALL = 2'b11
  } cmd_op_e;
  typedef enum logic [1:0] {IDLE, ISSUE, WAIT, RESP} state_e;
  localparam logic [7:0] RSP_TIMEOUT_DATA = 8'hFF;
endpackage

// File: rtl/sensor_read_scheduler_if.sv
// sensor_read_scheduler_if: command, sensor-controller and response channels of the scheduler
interface sensor_read_scheduler_if #(parameter int ADDR_W = 5);
  logic              cmd_valid;
  logic              cmd_ready;
  logic [1:0]        cmd_op;
  logic [ADDR_W-1:0] cmd_addr;
  logic              ctrl_start;
  logic [ADDR_W-1:0] ctrl_addr;
  logic              ctrl_done;
  logic [7:0]        ctrl_data;
  logic              rsp_valid;
  logic              rsp_ready;
  logic [ADDR_W-1:0] rsp_addr;
  logic [7:0]        rsp_data;
  logic              rsp_cont;
  logic              rsp_timeout;
  logic              cont_active;
  modport slave (
    input  cmd_valid, cmd_op, cmd_addr, ctrl_done, ctrl_data, rsp_ready,
    output cmd_ready, ctrl_start, ctrl_addr, rsp_valid, rsp_addr, rsp_data, rsp_cont, rsp_timeout, cont_active
  );
  modport master (
    output cmd_valid, cmd_op, cmd_addr, ctrl_done, ctrl_data, rsp_ready,
    input  cmd_ready, ctrl_start, ctrl_addr, rsp_valid, rsp_addr, rsp_data, rsp_cont, rsp_timeout, cont_active
  );
endinterface

// File: rtl/sensor_read_scheduler_rr_picker.sv
// rr_picker: rotating priority encoder, grants the lowest set request index >= ptr_i, wrapping
module rr_picker #(
  parameter  int N = 32,
  localparam int W = $clog2(N)
) (
  input  logic [N-1:0] req_i,
  input  logic [W-1:0] ptr_i,
  output logic         grant_valid_o,
  output logic [W-1:0] grant_idx_o
);
  always_comb begin
    grant_valid_o = |req_i;
    grant_idx_o = '0;
    for (int i = N - 1; i >= 0; i--)
      if (req_i[ptr_i + W'(i)]) grant_idx_o = ptr_i + W'(i);
  end
endmodule

// File: rtl/sensor_read_scheduler.sv
// sensor_read_scheduler: shares one sensor controller between one-shot and periodic reads.
// Define SCHED_OVERRUN_STAT_EN to add overrun_cnt, a saturating count of missed periodic reads.
module sensor_read_scheduler
  import sensor_sched_pkg::*;
#(
  parameter int ADDR_W      = 5,
  parameter int PERIOD_CYC  = 200000000,
  parameter int TIMEOUT_CYC = 5000000
) (
  input logic clk,
  input logic rst,
  sensor_read_scheduler_if.slave bus
`ifdef SCHED_OVERRUN_STAT_EN
  ,
  output logic [7:0] overrun_cnt
`endif
);
  localparam int N  = 1 << ADDR_W;
  localparam int PW = $clog2(PERIOD_CYC);
  localparam int TW = $clog2(TIMEOUT_CYC);
  state_e            state_q, state_d;
  logic [N-1:0]      cont_mask_q, cont_mask_d, pending_q, pending_d;
  logic              hold_valid_q, hold_valid_d, sel_cont_q, sel_cont_d;
  logic              rsp_cont_q, rsp_cont_d, rsp_timeout_q, rsp_timeout_d;
  logic [ADDR_W-1:0] hold_addr_q, hold_addr_d, sel_q, sel_d, rr_ptr_q, rr_ptr_d, rsp_addr_q, rsp_addr_d;
  logic [7:0]        rsp_data_q, rsp_data_d;
  logic [PW-1:0]     pcnt_q, pcnt_d;
  logic [TW-1:0]     tcnt_q, tcnt_d;
  logic              wrap, timed_out, grant_valid;
  logic [ADDR_W-1:0] grant_idx;
  rr_picker #(.N(N)) u_pick (
    .req_i(pending_q), .ptr_i(rr_ptr_q), .grant_valid_o(grant_valid), .grant_idx_o(grant_idx)
  );
  assign wrap      = pcnt_q == PW'(PERIOD_CYC - 1);
  assign timed_out = tcnt_q == TW'(TIMEOUT_CYC - 1);
  always_ff @(posedge clk) begin
    if (rst) begin
      state_q       <= IDLE;
      cont_mask_q   <= '0;
      pending_q     <= '0;
      hold_valid_q  <= 1'b0;
      hold_addr_q   <= '0;
      sel_q         <= '0;
      sel_cont_q    <= 1'b0;
      rr_ptr_q      <= '0;
      pcnt_q        <= '0;
      tcnt_q        <= '0;
      rsp_addr_q    <= '0;
      rsp_data_q    <= '0;
      rsp_cont_q    <= 1'b0;
      rsp_timeout_q <= 1'b0;
    end else begin
      state_q       <= state_d;
      cont_mask_q   <= cont_mask_d;
      pending_q     <= pending_d;
      hold_valid_q  <= hold_valid_d;
      hold_addr_q   <= hold_addr_d;
      sel_q         <= sel_d;
      sel_cont_q    <= sel_cont_d;
      rr_ptr_q      <= rr_ptr_d;
      pcnt_q        <= pcnt_d;
      tcnt_q        <= tcnt_d;
      rsp_addr_q    <= rsp_addr_d;
      rsp_data_q    <= rsp_data_d;
      rsp_cont_q    <= rsp_cont_d;
      rsp_timeout_q <= rsp_timeout_d;
    end
  end
  always_comb begin
    state_d = state_q;
    case (state_q)
      IDLE:    state_d = (hold_valid_q || grant_valid) ? ISSUE : IDLE;
      ISSUE:   state_d = WAIT;
      WAIT:    state_d = (bus.ctrl_done || timed_out) ? RESP : WAIT;
      RESP:    state_d = bus.rsp_ready ? IDLE : RESP;
      default: state_d = IDLE;
    endcase
  end
  always_comb begin
    pcnt_d        = wrap ? '0 : pcnt_q + 1'b1;
    tcnt_d        = (state_q == WAIT) ? tcnt_q + 1'b1 : '0;
    cont_mask_d   = cont_mask_q;
    pending_d     = pending_q | (wrap ? cont_mask_q : '0);
    hold_valid_d  = hold_valid_q;
    hold_addr_d   = hold_addr_q;
    sel_d         = sel_q;
    sel_cont_d    = sel_cont_q;
    rr_ptr_d      = rr_ptr_q;
    rsp_addr_d    = rsp_addr_q;
    rsp_data_d    = rsp_data_q;
    rsp_cont_d    = rsp_cont_q;
    rsp_timeout_d = rsp_timeout_q;
    if (state_q == IDLE && (hold_valid_q || grant_valid)) begin
      sel_d      = hold_valid_q ? hold_addr_q : grant_idx;
      sel_cont_d = !hold_valid_q;
    end
    if (state_q == ISSUE && sel_cont_q) begin
      pending_d[sel_q] = 1'b0;
      rr_ptr_d         = sel_q + 1'b1;
    end
    if (state_q == ISSUE && !sel_cont_q) hold_valid_d = 1'b0;
    if (state_q == WAIT && (bus.ctrl_done || timed_out)) begin
      rsp_addr_d    = sel_q;
      rsp_cont_d    = sel_cont_q;
      rsp_data_d    = bus.ctrl_done ? bus.ctrl_data : RSP_TIMEOUT_DATA;
      rsp_timeout_d = !bus.ctrl_done;
    end
    // Commands land after the wrap merge so a same-cycle stop still wins over the merge.
    if (bus.cmd_valid && !hold_valid_q) begin
      case (cmd_op_e'(bus.cmd_op))
        OP_SINGLE: begin
          hold_valid_d = 1'b1;
          hold_addr_d  = bus.cmd_addr;
        end
        OP_START: cont_mask_d[bus.cmd_addr] = 1'b1;
        OP_STOP: begin
          cont_mask_d[bus.cmd_addr] = 1'b0;
          pending_d[bus.cmd_addr]   = 1'b0;
        end
        default: begin
          cont_mask_d = '0;
          pending_d   = '0;
        end
      endcase
    end
  end
  assign bus.cmd_ready   = !hold_valid_q;
  assign bus.ctrl_start  = state_q == ISSUE;
  assign bus.ctrl_addr   = sel_q;
  assign bus.rsp_valid   = state_q == RESP;
  assign bus.rsp_addr    = rsp_addr_q;
  assign bus.rsp_data    = rsp_data_q;
  assign bus.rsp_cont    = rsp_cont_q;
  assign bus.rsp_timeout = rsp_timeout_q;
  assign bus.cont_active = |cont_mask_q;
`ifdef SCHED_OVERRUN_STAT_EN
  always_ff @(posedge clk) begin
    if (rst) overrun_cnt <= '0;
    else if (wrap && |(pending_q & cont_mask_q) && overrun_cnt != 8'hFF) overrun_cnt <= overrun_cnt + 1'b1;
  end
`endif
endmodule

// File: tb/tb_sensor_read_scheduler.sv
// tb_sensor_read_scheduler: directed vectors and corner sequences for sensor_read_scheduler
module tb_sensor_read_scheduler;
  import sensor_sched_pkg::*;
  localparam int AW = 5, PER = 1000, TO = 50;
  typedef struct {
    logic [AW-1:0] addr;
    logic [7:0]    data;
    logic          cont;
    logic          to;
  } rsp_t;
  typedef struct {
    logic [AW-1:0] addr;
    int            lat;
    int            dly;
    logic [7:0]    data;
    logic          to;
  } vec_t;
  logic clk = 1'b0, rst = 1'b1;
  always #5 clk = ~clk;
  sensor_read_scheduler_if #(.ADDR_W(AW)) bus ();
`ifdef SCHED_OVERRUN_STAT_EN
  logic [7:0] overrun_cnt;
`endif
  sensor_read_scheduler #(.ADDR_W(AW), .PERIOD_CYC(PER), .TIMEOUT_CYC(TO)) dut (
    .clk(clk), .rst(rst), .bus(bus)
`ifdef SCHED_OVERRUN_STAT_EN
    , .overrun_cnt(overrun_cnt)
`endif
  );
  int n_pass = 0, n_tot = 0;
  int ncyc = 0, rst_cyc = 0, acc_cyc = 0, start_cyc = 0, rv_cyc = 0, done_at = -1, ctl_lat = 0, nrdy_low = 0;
  logic [7:0] done_data;
  logic prev_rv = 1'b0;
  logic [AW-1:0] starts[$];
  rsp_t rsps[$];
  vec_t vt[5];

  function automatic void chk(string nm, logic [31:0] act, logic [31:0] exp);
    n_tot++;
    if (act === exp) n_pass++;
    else $display("FAIL %s: got %0h expected %0h", nm, act, exp);
  endfunction

  // One clock cycle: record what the DUT shows now, advance, then model the controller.
  task automatic step();
    rsp_t r;
    if (bus.ctrl_start) begin
      starts.push_back(bus.ctrl_addr);
      start_cyc = ncyc;
      done_at   = (ctl_lat != 0) ? ncyc + ctl_lat : -1;
      done_data = 8'(bus.ctrl_addr) + 8'h27;
    end
    if (bus.rsp_valid && !prev_rv) rv_cyc = ncyc;
    prev_rv = bus.rsp_valid;
    if (bus.rsp_valid && bus.rsp_ready) begin
      r.addr = bus.rsp_addr; r.data = bus.rsp_data; r.cont = bus.rsp_cont; r.to = bus.rsp_timeout;
      rsps.push_back(r);
    end
    if (bus.cmd_valid && bus.cmd_ready) acc_cyc = ncyc;
    if (!bus.cmd_ready && !rst) nrdy_low++;
    if (rst) rst_cyc = ncyc;
    @(negedge clk);
    ncyc++;
    bus.ctrl_done = (ncyc == done_at);
    bus.ctrl_data = (ncyc == done_at) ? done_data : 8'h00;
  endtask

  task automatic steps(input int n);
    for (int i = 0; i < n; i++) step();
  endtask

  task automatic send(input logic [1:0] op, input logic [AW-1:0] a);
    logic got = 1'b0;
    bus.cmd_valid = 1'b1; bus.cmd_op = op; bus.cmd_addr = a;
    for (int i = 0; i < 400 && !got; i++) begin
      got = bus.cmd_ready;
      step();
    end
    bus.cmd_valid = 1'b0;
    chk("cmd_accepted", 32'(got), 1);
  endtask

  task automatic wait_rsp(input int n);
    for (int i = 0; i < 3000 && rsps.size() < n; i++) step();
    chk("rsp_arrived", 32'(rsps.size() >= n), 1);
  endtask

  task automatic to_wrap();
    step();
    for (int i = 0; i < PER + 2 && (ncyc - rst_cyc) % PER != 1; i++) step();
  endtask

  task automatic do_reset();
    rst = 1'b1;
    steps(2);
    rst = 1'b0;
  endtask

  task automatic chk_reset_outputs(input string tag);
    chk({tag, "_cmd_ready"}, 32'(bus.cmd_ready), 1);
    chk({tag, "_ctrl_start"}, 32'(bus.ctrl_start), 0);
    chk({tag, "_ctrl_addr"}, 32'(bus.ctrl_addr), 0);
    chk({tag, "_rsp_valid"}, 32'(bus.rsp_valid), 0);
    chk({tag, "_rsp_addr"}, 32'(bus.rsp_addr), 0);
    chk({tag, "_rsp_data"}, 32'(bus.rsp_data), 0);
    chk({tag, "_rsp_cont"}, 32'(bus.rsp_cont), 0);
    chk({tag, "_rsp_timeout"}, 32'(bus.rsp_timeout), 0);
    chk({tag, "_cont_active"}, 32'(bus.cont_active), 0);
`ifdef SCHED_OVERRUN_STAT_EN
    chk({tag, "_overrun_cnt"}, 32'(overrun_cnt), 0);
`endif
  endtask

  task automatic check_reads(input string nm, input int s0, input int n0, input int exp_n,
                             input int ea[3], input int ec[3]);
    chk({nm, "_start_count"}, 32'(starts.size() - s0), 32'(exp_n));
    chk({nm, "_rsp_count"}, 32'(rsps.size() - n0), 32'(exp_n));
    for (int i = 0; i < exp_n && s0 + i < starts.size() && n0 + i < rsps.size(); i++) begin
      chk({nm, "_start_addr"}, 32'(starts[s0 + i]), 32'(ea[i]));
      chk({nm, "_rsp_addr"}, 32'(rsps[n0 + i].addr), 32'(ea[i]));
      chk({nm, "_rsp_cont"}, 32'(rsps[n0 + i].cont), 32'(ec[i]));
      chk({nm, "_rsp_data"}, 32'(rsps[n0 + i].data), 32'(8'(ea[i]) + 8'h27));
    end
  endtask

  initial begin
    #2_000_000;
    $display("FAIL watchdog: got timeout expected completion");
    $fatal(1, "watchdog");
  end

  initial begin
    int s0, n0;
    int ea[3], ec[3];
    bus.cmd_valid = 1'b0; bus.cmd_op = 2'b00; bus.cmd_addr = '0;
    bus.ctrl_done = 1'b0; bus.ctrl_data = 8'h00; bus.rsp_ready = 1'b1;
    do_reset();
    chk_reset_outputs("reset");

    // addr, controller latency, start-to-rsp_valid delay, data, timeout
    vt = '{'{5'd3, 40, 41, 8'h2A, 1'b0}, '{5'd0, 1, 2, 8'h27, 1'b0}, '{5'd31, 5, 6, 8'h46, 1'b0},
           '{5'd17, 0, 51, 8'hFF, 1'b1}, '{5'd8, 50, 51, 8'h2F, 1'b0}};
    foreach (vt[k]) begin
      ctl_lat = vt[k].lat;
      n0 = rsps.size(); s0 = starts.size();
      send(OP_SINGLE, vt[k].addr);
      wait_rsp(n0 + 1);
      chk("single_start_lat", 32'(start_cyc - acc_cyc), 2);
      chk("single_start_count", 32'(starts.size() - s0), 1);
      chk("single_ctrl_addr", 32'(starts[starts.size() - 1]), 32'(vt[k].addr));
      chk("single_rsp_delay", 32'(rv_cyc - start_cyc), 32'(vt[k].dly));
      chk("single_rsp_addr", 32'(rsps[n0].addr), 32'(vt[k].addr));
      chk("single_rsp_data", 32'(rsps[n0].data), 32'(vt[k].data));
      chk("single_rsp_cont", 32'(rsps[n0].cont), 0);
      chk("single_rsp_timeout", 32'(rsps[n0].to), 32'(vt[k].to));
      if (vt[k].to) begin
        bus.ctrl_done = 1'b1; bus.ctrl_data = 8'h55;
        steps(20);
        chk("late_done_rsp", 32'(rsps.size() - n0), 1);
        chk("late_done_start", 32'(starts.size() - s0), 1);
        chk("late_done_rsp_valid", 32'(bus.rsp_valid), 0);
      end
    end

    ctl_lat = 10;
    send(OP_START, 5'd1); send(OP_START, 5'd4); send(OP_START, 5'd30);
    step();
    chk("cont_active_on", 32'(bus.cont_active), 1);
    ea = '{1, 4, 30}; ec = '{1, 1, 1};
    for (int p = 0; p < 2; p++) begin
      to_wrap();
      s0 = starts.size(); n0 = rsps.size();
      steps(200);
      check_reads("cont_period", s0, n0, 3, ea, ec);
    end
    send(OP_STOP, 5'd4);
    to_wrap();
    s0 = starts.size(); n0 = rsps.size();
    steps(200);
    ea = '{1, 30, 0};
    check_reads("cont_after_stop", s0, n0, 2, ea, ec);
    send(OP_STOP_ALL, 5'd0);
    chk("cont_active_off", 32'(bus.cont_active), 0);
    to_wrap();
    s0 = starts.size(); n0 = rsps.size();
    steps(200);
    check_reads("cont_stopped", s0, n0, 0, ea, ec);

    ctl_lat = 20;
    send(OP_START, 5'd5); send(OP_START, 5'd9);
    to_wrap();
    s0 = starts.size(); n0 = rsps.size();
    for (int i = 0; i < 20 && starts.size() == s0; i++) step();
    send(OP_SINGLE, 5'd7);
    steps(300);
    ea = '{5, 7, 9}; ec = '{1, 0, 1};
    check_reads("priority", s0, n0, 3, ea, ec);
    send(OP_STOP_ALL, 5'd0);

    do_reset();
    ctl_lat = 10;
    bus.rsp_ready = 1'b0;
    send(OP_START, 5'd2);
    to_wrap();
    s0 = starts.size(); n0 = rsps.size(); nrdy_low = 0;
    to_wrap();
    send(OP_START, 5'd6); send(OP_STOP, 5'd6);
    to_wrap(); to_wrap();
    step();
    chk("stall_start_count", 32'(starts.size() - s0), 1);
    chk("stall_rsp_valid", 32'(bus.rsp_valid), 1);
    chk("stall_rsp_addr", 32'(bus.rsp_addr), 2);
`ifdef SCHED_OVERRUN_STAT_EN
    chk("overrun_cnt", 32'(overrun_cnt), 2);
`endif
    bus.rsp_ready = 1'b1;
    steps(200);
    ea = '{2, 2, 0}; ec = '{1, 1, 0};
    check_reads("stall_release", s0, n0, 2, ea, ec);
    chk("stall_cmd_ready_low", 32'(nrdy_low), 0);

    ctl_lat = 0;
    s0 = starts.size();
    send(OP_SINGLE, 5'd7);
    for (int i = 0; i < 10 && starts.size() == s0; i++) step();
    chk("rstwait_start_addr", 32'(starts[starts.size() - 1]), 7);
    steps(5);
    rst = 1'b1;
    step();
    rst = 1'b0;
    chk_reset_outputs("rst_in_wait");
    s0 = starts.size(); n0 = rsps.size();
    bus.ctrl_done = 1'b1; bus.ctrl_data = 8'h77;
    steps(100);
    chk("rst_stray_done_rsp", 32'(rsps.size() - n0), 0);
    chk("rst_stray_done_start", 32'(starts.size() - s0), 0);
    chk("rst_stray_rsp_valid", 32'(bus.rsp_valid), 0);

    $display("%0d/%0d checks passed", n_pass, n_tot);
    $finish;
  end
endmodule
